// File: rtl/seq_chunk_adder_pkg.sv
// Shared encodings and sizing helpers for the chunk-serial adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// CHUNK-bit combinational ripple-carry slice built from full-adder cells.
module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             C_in,
    output logic [CHUNK-1:0] Sum_out,
    output logic             C_out,
    output logic             C_msb
);
    logic [CHUNK:0] c;

    assign c[0] = C_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        rca_fa_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (Sum_out[i]),
            .co (c[i+1])
        );
    end

    assign C_out = c[CHUNK];
    // Carry into the top bit; XOR with C_out gives signed overflow.
    assign C_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/sub processing CHUNK bits per clock through one shared slice.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum_out,
    output logic             C_out,
    output logic             Ovf
);
    localparam int NCH = nch_of(WIDTH, CHUNK);
    localparam int CW  = cnt_width(NCH);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic            carry;

    logic [CHUNK-1:0] a_sl, b_sl, s_sl;
    logic             co_sl, cm_sl;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    rca_chunk #(.CHUNK(CHUNK)) u_slice (
        .A       (a_sl),
        .B       (b_sl),
        .C_in    (carry),
        .Sum_out (s_sl),
        .C_out   (co_sl),
        .C_msb   (cm_sl)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry   <= 1'b0;
            Sum_out <= '0;
            C_out   <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + ~borrow so one adder serves both modes.
                        a_q   <= A;
                        b_q   <= B ^ {WIDTH{Sub}};
                        carry <= Sub ? ~C_in : C_in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (cnt == CW'(i)) Sum_out[i*CHUNK +: CHUNK] <= s_sl;
                    end
                    carry <= co_sl;
                    if (cnt == CW'(NCH-1)) begin
                        C_out <= co_sl;
                        Ovf   <= cm_sl ^ co_sl;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized check of three adder configurations against an integer arithmetic model.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0: 16/4, dut1: 16/16, dut2: 32/8
    logic [15:0] a0, b0, s0, a1, b1, s1;
    logic [31:0] a2, b2, s2;
    logic iv0, ir0, ci0, sb0, ov0, or0, co0, of0;
    logic iv1, ir1, ci1, sb1, ov1, or1, co1, of1;
    logic iv2, ir2, ci2, sb2, ov2, or2, co2, of2;

    int n_vec = 0;
    int n_err = 0;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .C_in(ci0), .Sub(sb0), .out_valid(ov0), .out_ready(or0), .Sum_out(s0),
        .C_out(co0), .Ovf(of0));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .C_in(ci1), .Sub(sb1), .out_valid(ov1), .out_ready(or1), .Sum_out(s1),
        .C_out(co1), .Ovf(of1));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .C_in(ci2), .Sub(sb2), .out_valid(ov2), .out_ready(or2), .Sum_out(s2),
        .C_out(co2), .Ovf(of2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic iv, input logic ordy);
        case (sel)
            0: begin a0 = a[15:0]; b0 = b[15:0]; ci0 = ci; sb0 = sb; iv0 = iv; or0 = ordy; end
            1: begin a1 = a[15:0]; b1 = b[15:0]; ci1 = ci; sb1 = sb; iv1 = iv; or1 = ordy; end
            default: begin a2 = a; b2 = b; ci2 = ci; sb2 = sb; iv2 = iv; or2 = ordy; end
        endcase
    endtask

    task automatic rd(input int sel, output logic [31:0] s, output logic co, output logic of,
                      output logic ir, output logic ovl);
        case (sel)
            0: begin s = {16'h0, s0}; co = co0; of = of0; ir = ir0; ovl = ov0; end
            1: begin s = {16'h0, s1}; co = co1; of = of1; ir = ir1; ovl = ov1; end
            default: begin s = s2; co = co2; of = of2; ir = ir2; ovl = ov2; end
        endcase
    endtask

    // Reference: exact integer add/sub, then wrap and range-check.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co, output logic of);
        longint m, la, lb, sa, sbv, r, rs, c;
        m   = longint'(1) << w;
        la  = longint'({32'h0, a}) & (m - 1);
        lb  = longint'({32'h0, b}) & (m - 1);
        sa  = (la >= m / 2) ? la - m : la;
        sbv = (lb >= m / 2) ? lb - m : lb;
        c   = ci ? 1 : 0;
        r   = sb ? la - lb - c : la + lb + c;
        rs  = sb ? sa - sbv - c : sa + sbv + c;
        s   = 32'(((r % m) + m) % m);
        co  = sb ? (r >= 0) : (r >= m);
        of  = (rs < -(m / 2)) || (rs >= m / 2);
    endtask

    task automatic op(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb, input int hold);
        int w, nch, lat;
        logic [31:0] s, es;
        logic co, of, ir, ovl, eco, eof;
        w   = (sel == 2) ? 32 : 16;
        nch = (sel == 1) ? 1 : 4;
        model(w, a, b, ci, sb, es, eco, eof);
        @(negedge clk);
        rd(sel, s, co, of, ir, ovl);
        chk("accept_ready", 64'(ir), 64'(1));
        drv(sel, a, b, ci, sb, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drv(sel, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        lat = 0;
        rd(sel, s, co, of, ir, ovl);
        while (!ovl && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            rd(sel, s, co, of, ir, ovl);
        end
        chk("latency", 64'(lat), 64'(nch));
        chk("sum", 64'(s), 64'(es));
        chk("c_out", 64'(co), 64'(eco));
        chk("ovf", 64'(of), 64'(eof));
        repeat (hold) begin
            drv(sel, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            @(posedge clk);
            #1;
            rd(sel, s, co, of, ir, ovl);
            chk("hold_sum", 64'(s), 64'(es));
            chk("hold_flags", 64'({co, of, ir, ovl}), 64'({eco, eof, 1'b0, 1'b1}));
        end
        @(negedge clk);
        drv(sel, a, b, ci, sb, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rd(sel, s, co, of, ir, ovl);
        chk("release", 64'({ir, ovl}), 64'({1'b1, 1'b0}));
        drv(sel, a, b, ci, sb, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=done");
        $fatal(1);
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_vals", 64'({s0, co0, of0, ir0, ov0}), 64'({16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
        chk("rst_vals2", 64'({s2, co2, of2, ir2, ov2}), 64'({32'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 32'h0003, 32'h0006, 1'b0, 1'b0, 0);
        chk("t1_sum", 64'({s0, co0, of0}), 64'({16'h0009, 1'b0, 1'b0}));
        op(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 0);
        chk("t2a", 64'({s0, co0, of0}), 64'({16'h0000, 1'b1, 1'b0}));
        op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 0);
        chk("t2b", 64'({s0, co0, of0}), 64'({16'h8000, 1'b0, 1'b1}));
        op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 0);
        chk("t3a", 64'({s0, co0, of0}), 64'({16'hFFFE, 1'b0, 1'b0}));
        op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 0);
        chk("t3b", 64'({s0, co0, of0}), 64'({16'h7FFF, 1'b1, 1'b1}));
        op(0, 32'h0005, 32'h0002, 1'b1, 1'b1, 0);
        chk("t3c", 64'({s0, co0}), 64'({16'h0002, 1'b1}));

        op(0, 32'h1357, 32'h2468, 1'b0, 1'b0, 10);

        // Asynchronous reset two chunks into an operation.
        @(negedge clk);
        drv(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 iv0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst", 64'({s0, co0, of0, ir0, ov0}), 64'({16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 0);
        chk("post_rst", 64'(s0), 64'(16'h2345));

        for (int i = 0; i < 1000; i++)
            op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        for (int i = 0; i < 1000; i++)
            op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, using one shared CHUNK-bit ripple-carry slice. It generalises the 4-bit ripple carry adder to arbitrary width, adds a subtract mode and signed-overflow flag, and wraps the datapath in valid/ready handshakes. It serves as the area-optimised arithmetic unit for wide datapaths where one result per WIDTH/CHUNK + 2 cycles is sufficient.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK, otherwise elaboration error
- CHUNK, 4, bits added per cycle; NCH = WIDTH/CHUNK; CHUNK == WIDTH legal (NCH = 1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A (unsigned or two's complement)
- B  in  WIDTH  operand B
- C_in  in  1  carry-in (add) / borrow-in (sub)
- Sub  in  1  0 = A+B+C_in, 1 = A-B-C_in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- Sum_out  out  WIDTH  result
- C_out  out  1  carry out of MSB (sub: 1 = no borrow)
- Ovf  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch A, B^{WIDTH{Sub}} and carry = Sub ? ~C_in : C_in; cnt=0; go RUN. Other inputs ignored.
- RUN: feed chunk cnt of the latched operands plus carry register into the slice; write the slice sum into Sum_out[cnt*CHUNK +: CHUNK]; carry <= slice carry-out; cnt++. When cnt == NCH-1: set C_out = slice carry-out; Ovf = slice carry into MSB XOR slice carry-out; go DONE.
- DONE: out_valid=1, in_ready=0. On out_ready: go IDLE. Sum_out/C_out/Ovf stay unchanged until the next operation overwrites them chunk by chunk.
- Arithmetic is modulo 2^WIDTH. No saturation.
- in_ready is 0 in RUN and DONE. in_valid in those states is dropped, not queued.
- Inputs A/B/C_in/Sub may change freely after acceptance; the result uses the latched values.
- Reset (any state, including mid-RUN): asynchronously go to IDLE. The operation in flight is discarded.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, Sum_out=0, C_out=0, Ovf=0, cnt=0, carry=0.
- Accept at edge k (IDLE, in_valid=1). RUN occupies edges k+1..k+NCH. out_valid rises after edge k+NCH.
- Result held while out_valid=1 and out_ready=0, for any duration.
- Handshake on edge with out_valid & out_ready: out_valid falls, in_ready rises after that edge. Next accept is earliest on the following edge.
- Throughput: one op per NCH+2 cycles.
- All outputs are registered except in_ready and out_valid, which are decoded from the state register.

## Structure
- Package seq_adder_pkg:
  - state encoding localparams IDLE/RUN/DONE (2 bits)
  - NCH derivation helper
  - counter width = clog2(NCH), minimum 1
- Sub-module rca_chunk (combinational, CHUNK-parameterised ripple-carry slice):
  - ports A, B, C_in, Sum_out, C_out, C_msb (carry into top bit)
  - built from full-adder bit cells
- Top level:
  - FSM, cnt, operand/carry registers
  - result register with chunk-indexed write enable

## Test plan
All cases WIDTH=16, CHUNK=4 unless noted.

1. A=16'h0003, B=16'h0006, C_in=0, Sub=0 -> Sum_out=16'h0009, C_out=0, Ovf=0. out_valid asserted exactly 4 edges after acceptance.
2. Full ripple: A=16'hFFFF, B=16'h0000, C_in=1 -> Sum_out=16'h0000, C_out=1, Ovf=0. Then A=16'h7FFF, B=16'h0001 -> 16'h8000, C_out=0, Ovf=1.
3. Subtract: A=16'h0005, B=16'h0007, Sub=1, C_in=0 -> 16'hFFFE, C_out=0, Ovf=0. Then A=16'h8000, B=16'h0001, Sub=1 -> 16'h7FFF, C_out=1, Ovf=1. Then borrow-in: A=16'h0005, B=16'h0002, Sub=1, C_in=1 -> 16'h0002, C_out=1.
4. Backpressure: out_ready=0 for 10 cycles after out_valid while toggling in_valid/A/B -> Sum_out/C_out/Ovf stable, in_ready=0, no new op accepted. Raise out_ready -> in_ready=1 on the next cycle.
5. Reset: assert rst_n=0 asynchronously mid-RUN (cnt=2) -> all outputs at reset values immediately. After release, op 16'h1234+16'h1111 -> 16'h2345.
6. Parameter sweep: CHUNK=16 (1 RUN cycle) and WIDTH=32/CHUNK=8. 1000 random ops each, compared against a reference add/sub -> zero mismatches, latency NCH.
